// File: rtl/stream_pkg.sv
// Shared definitions for the pixel-stream source/sink pair: FSM encoding,
// LFSR constants and frame-length helper.
package stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_STOPPED = 2'd3
  } state_e;

  // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  function automatic logic [31:0] frame_len(input int unsigned w, input int unsigned h);
    return 32'(w * h);
  endfunction

endpackage

// File: rtl/axis_frame_sink_lfsr16.sv
// 16-bit left-shifting Fibonacci LFSR with synchronous load and hold.
module lfsr16
  import stream_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        enable,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic w_fb;
  assign w_fb = ^(state & LFSR_TAPS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      state <= RESET_VAL;
    else if (load)   state <= seed;
    else if (enable) state <= {state[14:0], w_fb};
  end

endmodule

// File: rtl/axis_frame_sink.sv
// Stream sink: drives TREADY with optional pseudo-random back-pressure, counts
// beats, checks TLAST placement and folds pixels into a rotate-xor signature.
module axis_frame_sink
  import stream_pkg::*;
#(
  parameter int          DATA_W    = 8,
  parameter int          WIDTH     = 64,
  parameter int          HEIGHT    = 64,
  parameter logic [15:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_in,
  input  logic              stop_in,
  input  logic              bp_enable,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  input  logic              last_in,
  output logic              ready,
  output logic [31:0]       beat_count,
  output logic [31:0]       checksum,
  output logic              frame_done,
  output logic              err_last_early,
  output logic              err_last_missing,
  output logic              err_extra
);

  localparam logic [31:0] N = frame_len(WIDTH, HEIGHT);

  state_e      r_state, w_next;
  logic [15:0] w_lfsr;
  logic        w_ready, w_accept, w_last_beat, w_clear, w_lfsr_load, w_lfsr_en;
  logic [31:0] r_beat_count, r_checksum;
  logic        r_frame_done, r_err_early, r_err_missing, r_err_extra;

  // ready depends only on registered state (and the static mode pin), never on valid
  assign w_ready     = (r_state == ST_RUN) && (bp_enable ? w_lfsr[0] : 1'b1);
  assign w_accept    = valid && w_ready;
  assign w_last_beat = (r_beat_count == N - 32'd1);
  assign w_lfsr_load = (w_next == ST_RUN) && (r_state != ST_RUN);
  assign w_lfsr_en   = (r_state == ST_RUN);

  lfsr16 #(.RESET_VAL(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .load   (w_lfsr_load),
    .enable (w_lfsr_en),
    .seed   (LFSR_SEED),
    .state  (w_lfsr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (stop_in) begin
          w_next = ST_STOPPED;
        end else if (start_in) begin
          w_next  = ST_RUN;
          w_clear = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop_in)                       w_next = ST_STOPPED;
        else if (w_accept && w_last_beat)  w_next = ST_DONE;
      end
      default: w_next = ST_STOPPED;
    endcase
  end

  // A handshake coinciding with stop_in is still recorded; STOPPED freezes everything after
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_beat_count  <= '0;
      r_checksum    <= '0;
      r_frame_done  <= 1'b0;
      r_err_early   <= 1'b0;
      r_err_missing <= 1'b0;
      r_err_extra   <= 1'b0;
    end else if (w_clear) begin
      r_beat_count  <= '0;
      r_checksum    <= '0;
      r_frame_done  <= 1'b0;
      r_err_early   <= 1'b0;
      r_err_missing <= 1'b0;
      r_err_extra   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_beat_count <= r_beat_count + 32'd1;
        r_checksum   <= {r_checksum[30:0], r_checksum[31]} ^ 32'(data_in);
        if (last_in && !w_last_beat) r_err_early <= 1'b1;
        if (w_last_beat) begin
          r_frame_done <= 1'b1;
          if (!last_in) r_err_missing <= 1'b1;
        end
      end
      if (r_state == ST_DONE && valid) r_err_extra <= 1'b1;
    end
  end

  assign ready            = w_ready;
  assign beat_count       = r_beat_count;
  assign checksum         = r_checksum;
  assign frame_done       = r_frame_done;
  assign err_last_early   = r_err_early;
  assign err_last_missing = r_err_missing;
  assign err_extra        = r_err_extra;

endmodule

// File: tb/tb_axis_frame_sink.sv
// Directed bench for axis_frame_sink with an 8-beat (4x2) frame.
module tb_axis_frame_sink;

  localparam int          DATA_W = 8;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start_in = 1'b0, stop_in = 1'b0, bp_enable = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              valid = 1'b0, last_in = 1'b0;
  logic              ready, frame_done, err_last_early, err_last_missing, err_extra;
  logic [31:0]       beat_count, checksum;

  int n_checks = 0;
  int n_errors = 0;

  axis_frame_sink #(.DATA_W(DATA_W), .WIDTH(4), .HEIGHT(2), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset(reset), .start_in(start_in), .stop_in(stop_in),
    .bp_enable(bp_enable), .data_in(data_in), .valid(valid), .last_in(last_in),
    .ready(ready), .beat_count(beat_count), .checksum(checksum),
    .frame_done(frame_done), .err_last_early(err_last_early),
    .err_last_missing(err_last_missing), .err_extra(err_extra)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        bp;
    logic [7:0]  last_mask;   // bit k = TLAST on beat index k
    logic [7:0]  data_fix;    // 0 -> data = k+1
    logic        exp_early;
    logic        exp_missing;
    logic [31:0] exp_cs;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent model: feedback = s15^s13^s12^s10 shifted in at bit 0
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_count"}, beat_count, 32'd0);
    check({tag, "_cs"}, checksum, 32'd0);
    check({tag, "_flags"}, {28'd0, frame_done, err_last_early, err_last_missing, err_extra}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0; start_in = 0; stop_in = 0; valid = 0; last_in = 0;
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input vec_t v);
    logic [15:0] m;
    logic        acc;
    int          k, cyc;
    bp_enable = v.bp;
    start_in  = 1'b1;
    @(posedge clk); #1;
    start_in  = 1'b0;
    check("start_count", beat_count, 32'd0);
    check("start_flags", {28'd0, frame_done, err_last_early, err_last_missing, err_extra}, 32'd0);
    m = SEED; k = 0; cyc = 0;
    while (k < 8 && cyc < 200) begin
      valid   = 1'b1;
      data_in = (v.data_fix != 0) ? v.data_fix : 8'(k + 1);
      last_in = v.last_mask[k];
      check("ready_run", 32'(ready), v.bp ? 32'(m[0]) : 32'd1);
      acc = ready;
      @(posedge clk); #1;
      m = lfsr_step(m);
      cyc++;
      if (acc) begin
        k++;
        check("count_step", beat_count, 32'(k));
        check("done_lat", 32'(frame_done), (k == 8) ? 32'd1 : 32'd0);
      end
    end
    valid = 1'b0; last_in = 1'b0;
    if (k < 8) check("frame_timeout", 32'(k), 32'd8);
    check("ready_done", 32'(ready), 32'd0);
    check("count_end", beat_count, 32'd8);
    check("cs_end", checksum, v.exp_cs);
    check("err_early", 32'(err_last_early), 32'(v.exp_early));
    check("err_missing", 32'(err_last_missing), 32'(v.exp_missing));
    check("err_extra0", 32'(err_extra), 32'd0);
  endtask

  initial begin
    // checksum for data 1..8 is 0x16; for eight 0xFF beats it is 0x5555
    tbl[0] = '{1'b0, 8'h80, 8'h00, 1'b0, 1'b0, 32'h16};
    tbl[1] = '{1'b1, 8'h80, 8'h00, 1'b0, 1'b0, 32'h16};
    tbl[2] = '{1'b0, 8'h84, 8'h00, 1'b1, 1'b0, 32'h16};
    tbl[3] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 32'h16};
    tbl[4] = '{1'b1, 8'h80, 8'hFF, 1'b0, 1'b0, 32'h5555};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      check("idle_ready", 32'(ready), 32'd0);
      run_frame(tbl[i]);
    end

    // Missing TLAST, then valid in DONE, then restart from DONE
    do_reset();
    run_frame(tbl[3]);
    valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 valid = 1'b0;
    check("extra_set", 32'(err_extra), 32'd1);
    check("extra_count", beat_count, 32'd8);
    check("extra_done", 32'(frame_done), 32'd1);
    run_frame(tbl[0]);

    // Stop coinciding with beat 5: beat counted, then frozen
    do_reset();
    bp_enable = 1'b0; start_in = 1'b1;
    @(posedge clk); #1 start_in = 1'b0;
    for (int b = 0; b < 5; b++) begin
      valid = 1'b1; data_in = 8'(b + 1); last_in = 1'b0;
      stop_in = (b == 4);
      @(posedge clk); #1;
    end
    stop_in = 1'b0;
    check("stop_count", beat_count, 32'd5);
    check("stop_ready", 32'(ready), 32'd0);
    start_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 start_in = 1'b0; valid = 1'b0;
    check("stopped_count", beat_count, 32'd5);
    check("stopped_ready", 32'(ready), 32'd0);
    check("stopped_done", 32'(frame_done), 32'd0);

    // Asynchronous reset in the middle of a frame
    do_reset();
    bp_enable = 1'b0; start_in = 1'b1;
    @(posedge clk); #1 start_in = 1'b0;
    for (int b = 0; b < 3; b++) begin
      valid = 1'b1; data_in = 8'(b + 1);
      @(posedge clk); #1;
    end
    check("mid_count", beat_count, 32'd3);
    reset = 1'b0;
    #2 check_zero("async_rst");
    #1 reset = 1'b1; valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(ready), 32'd0);
    check("post_rst_count", beat_count, 32'd0);
    @(posedge clk); #1;
    check("idle_hold_ready", 32'(ready), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_frame_sink.md
Name: axis_frame_sink

Overview:
- Downstream consumer of the hls_target output stream (hw_output_1_TDATA/TVALID/TREADY/TLAST).
- Drives TREADY with a programmable back-pressure pattern, counts accepted beats, checks TLAST placement against the expected frame size, and folds the pixels into a signature.
- Reports frame completion and sticky protocol errors, so a bench or on-chip monitor can judge a run without a pixel dump.

Parameters:
- DATA_W, 8, pixel width on data_in.
- WIDTH, 64, pixels per line.
- HEIGHT, 64, lines per frame; frame length N = WIDTH*HEIGHT beats.
- LFSR_SEED, 16'hACE1, back-pressure LFSR seed; must be nonzero.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start_in  in  1  level or pulse; arms a frame capture.
- stop_in  in  1  abort; freezes results.
- bp_enable  in  1  1 = pseudo-random back-pressure, 0 = ready held high while running.
- data_in  in  DATA_W  stream pixel (TDATA).
- valid  in  1  stream TVALID.
- last_in  in  1  stream TLAST.
- ready  out  1  stream TREADY.
- beat_count  out  32  accepted beats this frame.
- checksum  out  32  running signature.
- frame_done  out  1  high once beat N-1 has been accepted; stays high until restart or reset.
- err_last_early  out  1  sticky; TLAST on beat index < N-1.
- err_last_missing  out  1  sticky; beat N-1 accepted without TLAST.
- err_extra  out  1  sticky; valid seen while in DONE.

Behaviour:
- Reset (async, reset=0):
  - State = IDLE; LFSR = LFSR_SEED.
  - All outputs 0: ready, counters, checksum, frame_done and all errors.
- States are IDLE, RUN, DONE, STOPPED.
- Handshake:
  - A beat is accepted only on a rising edge with valid && ready.
  - ready is a registered-state function: in RUN it is (bp_enable ? lfsr[0] : 1); in every other state it is 0.
  - ready never depends combinationally on valid.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every cycle in RUN, independent of valid; held in other states.
  - Reloaded with LFSR_SEED on every transition into RUN.
- IDLE -> RUN when start_in=1 and stop_in=0.
  - On entry: beat_count, checksum, frame_done and all errors are cleared.
- Accepting beat index k (beat_count before update):
  - beat_count <= k+1.
  - checksum <= {checksum[30:0], checksum[31]} ^ zero_extend(data_in).
  - If last_in=1 and k < N-1: set err_last_early; keep running (no resync).
  - If k == N-1:
    - If last_in=0, set err_last_missing.
    - Go to DONE; frame_done=1 from the next cycle.
    - ready deasserts in the same edge, so latency from final handshake to frame_done is 1 cycle.
- DONE:
  - valid=1 in any cycle sets err_extra.
  - start_in=1 (with stop_in=0) -> RUN with a full clear, as on IDLE exit.
- stop_in=1 in any state:
  - Go to STOPPED next edge; ready=0; counters, checksum and flags are frozen.
  - STOPPED exits only via reset.
- Simultaneous events:
  - stop_in beats start_in.
  - start_in in RUN is ignored.
  - A handshake in the same cycle as stop_in is still counted; stop takes effect on the following cycle.
- beat_count wraps modulo 2^32; this is unreachable for legal N.
- Reset mid-frame: immediate clear; no partial results retained.

Decomposition:
- Shared package (stream_pkg):
  - State encoding enum (IDLE=0, RUN=1, DONE=2, STOPPED=3).
  - LFSR tap mask constant 16'hB400 and default seed.
  - Frame-size localparam helper N = WIDTH*HEIGHT.
- Sub-module lfsr16:
  - Ports: clk, reset, load, enable, seed, state.
  - Reusable by the matching upstream source for randomized valid.

Test Plan:
- No back-pressure: WIDTH=4, HEIGHT=2, bp_enable=0, 8 beats data 1..8 with last on beat 8 -> ready=1 throughout RUN; beat_count=8; frame_done 1 cycle after the 8th handshake; no error flags; checksum matches the reference model of the rotate-xor over 1..8.
- Back-pressure: same frame, bp_enable=1, seed 16'hACE1 -> ready toggles per lfsr[0]; no beat lost or duplicated; beat_count=8; checksum identical to the bp_enable=0 run.
- Early TLAST: last on beat 3 of 8 -> err_last_early=1; capture continues; frame_done after beat 8; err_last_missing=0.
- Missing TLAST: beat 8 with last=0 -> err_last_missing=1 and frame_done=1; then valid=1 for 2 cycles in DONE -> err_extra=1, beat_count stays 8.
- Stop and restart: stop_in pulsed after beat 5 -> ready=0 next cycle, beat_count frozen at 5, and start_in ignored afterwards; separately, start_in from DONE -> flags and counters clear, second frame counts to 8 again.
- Reset mid-frame: reset=0 for 1 cycle at beat 3 -> all outputs 0 asynchronously (before the next clock edge); after release, state is IDLE with ready=0 until start_in.
